// File: rtl/dct_pass_sequencer_if.sv
// Kernel-side handshake bundle for the 2-D DCT pass sequencer.
// master: the sequencer (issues vectors); slave: the 1-D kernel datapath.
interface dct_pass_sequencer_if #(
    parameter int unsigned MAX_N_LOG2 = 5
) ();
    logic                  krn_valid;
    logic                  krn_ready;
    logic [MAX_N_LOG2-1:0] krn_vec_idx;
    logic                  krn_pass;
    logic [2:0]            krn_len_log2;
    logic                  krn_res_valid;

    modport master (
        output krn_valid,
        output krn_vec_idx,
        output krn_pass,
        output krn_len_log2,
        input  krn_ready,
        input  krn_res_valid
    );

    modport slave (
        input  krn_valid,
        input  krn_vec_idx,
        input  krn_pass,
        input  krn_len_log2,
        output krn_ready,
        output krn_res_valid
    );
endinterface

// File: rtl/dct_pass_sequencer.sv
// 2-D forward DCT pass sequencer: row pass of N vectors, then column pass of N
// vectors through the shared 1-D kernel, with a bounded number in flight.
// Optional macro DCT_PASS_SEQ_PERF_CNT_EN adds a saturating busy-cycle counter.
module dct_pass_sequencer #(
    parameter int unsigned MAX_N_LOG2      = 5,
    parameter int unsigned MAX_OUTSTANDING = 4
`ifdef DCT_PASS_SEQ_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W          = 32
`endif
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cfg_start,
    input  logic [2:0]          cfg_size_log2,
    input  logic                cfg_abort,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_err,
`ifdef DCT_PASS_SEQ_PERF_CNT_EN
    output logic [PERF_W-1:0]   perf_cycles,
`endif
    dct_pass_sequencer_if.master krn
);
    localparam int unsigned CntW    = MAX_N_LOG2 + 1;
    localparam logic [2:0]  MinSize = 3'd2;
    localparam logic [2:0]  MaxSize = 3'(MAX_N_LOG2);
    localparam logic [3:0]  MaxOut  = 4'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        StIdle, StRowIssue, StRowDrain, StColIssue, StColDrain, StDone, StAbort
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            size_q, size_d;
    logic                  pass_q, pass_d;
    logic [MAX_N_LOG2-1:0] issue_cnt_q, issue_cnt_d;
    logic [CntW-1:0]       ret_cnt_q, ret_cnt_d;
    logic [3:0]            out_cnt_q, out_cnt_d;
    logic                  err_q, err_d;

    logic            in_issue, in_run, issuing, hs, res_eff, size_ok, last_issue, pass_done;
    logic [CntW-1:0] n_blk, ret_sum;

    assign in_issue = (state_q == StRowIssue) || (state_q == StColIssue);
    assign in_run   = in_issue || (state_q == StRowDrain) || (state_q == StColDrain);
    // Slot check uses the registered count: a same-cycle return frees a slot next cycle.
    assign issuing  = in_issue && (out_cnt_q < MaxOut);
    assign hs       = issuing && krn.krn_ready;
    // Stray results with nothing outstanding are dropped so the count never underflows.
    assign res_eff  = krn.krn_res_valid && (out_cnt_q != 4'd0);
    assign size_ok  = (cfg_size_log2 >= MinSize) && (cfg_size_log2 <= MaxSize);
    assign n_blk    = CntW'(1) << size_q;
    assign last_issue = ({1'b0, issue_cnt_q} == (n_blk - CntW'(1)));
    assign ret_sum  = ret_cnt_q + CntW'(res_eff);
    assign pass_done = (ret_sum == n_blk);

    // Next-state and counter updates.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        pass_d      = pass_q;
        issue_cnt_d = hs ? issue_cnt_q + MAX_N_LOG2'(1) : issue_cnt_q;
        ret_cnt_d   = ret_sum;
        out_cnt_d   = out_cnt_q + {3'b000, hs} - {3'b000, res_eff};
        err_d       = err_q;
        if (in_run && cfg_abort) begin
            state_d = StAbort;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_start) begin
                        if (size_ok) begin
                            size_d      = cfg_size_log2;
                            err_d       = 1'b0;
                            pass_d      = 1'b0;
                            issue_cnt_d = '0;
                            ret_cnt_d   = '0;
                            state_d     = StRowIssue;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StRowIssue: if (hs && last_issue) state_d = StRowDrain;
                StRowDrain: begin
                    if (pass_done) begin
                        issue_cnt_d = '0;
                        ret_cnt_d   = '0;
                        pass_d      = 1'b1;
                        state_d     = StColIssue;
                    end
                end
                StColIssue: if (hs && last_issue) state_d = StColDrain;
                StColDrain: if (pass_done) state_d = StDone;
                StDone:     state_d = StIdle;
                StAbort:    if (out_cnt_d == 4'd0) state_d = StIdle;
                default:    state_d = StIdle;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= StIdle;
            size_q      <= 3'd2;
            pass_q      <= 1'b0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            out_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            pass_q      <= pass_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            out_cnt_q   <= out_cnt_d;
            err_q       <= err_d;
        end
    end

    assign cfg_busy         = (state_q != StIdle);
    assign cfg_done         = (state_q == StDone);
    assign cfg_err          = err_q;
    assign krn.krn_valid    = issuing;
    assign krn.krn_vec_idx  = issue_cnt_q;
    assign krn.krn_pass     = pass_q;
    assign krn.krn_len_log2 = size_q;

`ifdef DCT_PASS_SEQ_PERF_CNT_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    // Busy-cycle counter: cleared on accepted start, saturating.
    always_comb begin
        perf_d = perf_q;
        if ((state_q == StIdle) && cfg_start && size_ok) begin
            perf_d = '0;
        end else if (cfg_busy && (perf_q != '1)) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_dct_pass_sequencer.sv
// Directed bench for dct_pass_sequencer: a kernel emulator with a fixed
// result delay, a per-cycle monitor holding an expected-issue queue and an
// outstanding count, plus hand-computed latency expectations.
module tb_dct_pass_sequencer;
    localparam int MAX_OUT = 4;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       cfg_start;
    logic [2:0] cfg_size_log2;
    logic       cfg_abort;
    logic       cfg_busy, cfg_done, cfg_err;
`ifdef DCT_PASS_SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    dct_pass_sequencer_if #(.MAX_N_LOG2(5)) kif ();

    dct_pass_sequencer #(.MAX_N_LOG2(5), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .cfg_start     (cfg_start),
        .cfg_size_log2 (cfg_size_log2),
        .cfg_abort     (cfg_abort),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
`ifdef DCT_PASS_SEQ_PERF_CNT_EN
        .perf_cycles   (perf_cycles),
`endif
        .krn           (kif.master)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int res_delay = 2;
    int due_q[$];
    int exp_q[$];
    int cur_size = 2;
    int out_model = 0;
    int max_out = 0;
    int same3 = 0;
    int hs_total = 0;
    int hs_base = 0;
    int done_cnt = 0;
    int start_cyc = 0;
    int first_hs = -1;
    int first_col = -1;
    int done_cyc = -1;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Kernel emulator: each accepted vector returns one result res_delay cycles later.
    initial begin
        kif.krn_res_valid = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            kif.krn_res_valid = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                kif.krn_res_valid = 1'b1;
                void'(due_q.pop_front());
            end
        end
    end

    // Monitor: compares every handshake with the expected order and tracks outstanding.
    initial begin
        bit hs, res;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                out_model = 0;
            end else begin
                hs  = kif.krn_valid && kif.krn_ready;
                res = kif.krn_res_valid && (out_model > 0);
                if (kif.krn_valid) chk("valid_below_limit", int'(out_model < MAX_OUT), 1);
                if (hs) begin
                    hs_total++;
                    due_q.push_back(cyc + res_delay);
                    if (first_hs < 0) first_hs = cyc;
                    if (kif.krn_pass && first_col < 0) first_col = cyc;
                    chk("issue_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0)
                        chk("issue_pass_idx", int'(kif.krn_pass) * 64 + int'(kif.krn_vec_idx),
                            exp_q.pop_front());
                    chk("issue_len", int'(kif.krn_len_log2), cur_size);
                end
                if (hs && res && out_model == 3) same3++;
                out_model = out_model + int'(hs) - int'(res);
                if (out_model > max_out) max_out = out_model;
                if (cfg_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("done_all_issued", exp_q.size(), 0);
                    chk("done_all_returned", out_model, 0);
                end
            end
        end
    end

    task automatic do_start(input int sz, input bit fill);
        @(posedge ACLK);
        #1;
        cfg_start     = 1'b1;
        cfg_size_log2 = 3'(sz);
        if (fill) begin
            cur_size = sz;
            exp_q.delete();
            for (int p = 0; p < 2; p++)
                for (int i = 0; i < (1 << sz); i++) exp_q.push_back(p * 64 + i);
        end
        start_cyc = cyc;
        first_hs  = -1;
        first_col = -1;
        done_cyc  = -1;
        hs_base   = hs_total;
        max_out   = 0;
        same3     = 0;
        @(posedge ACLK);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = done_cnt;
        int k = 0;
        while (done_cnt == n && k < limit) begin
            @(posedge ACLK);
            k++;
        end
        chk("done_seen_in_time", int'(done_cnt != n), 1);
        repeat (3) @(posedge ACLK);
    endtask

    task automatic check_reset_outs();
        chk("rst_busy", int'(cfg_busy), 0);
        chk("rst_done", int'(cfg_done), 0);
        chk("rst_err", int'(cfg_err), 0);
        chk("rst_valid", int'(kif.krn_valid), 0);
        chk("rst_idx", int'(kif.krn_vec_idx), 0);
        chk("rst_pass", int'(kif.krn_pass), 0);
        chk("rst_len", int'(kif.krn_len_log2), 2);
`ifdef DCT_PASS_SEQ_PERF_CNT_EN
        chk("rst_perf", int'(perf_cycles), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int d0;
        int t_abort;
        int bad;
        ARESET        = 1'b1;
        cfg_start     = 1'b0;
        cfg_size_log2 = 3'd2;
        cfg_abort     = 1'b0;
        kif.krn_ready = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check_reset_outs();
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;

        // N=4, delay 2: exact latencies.
        res_delay = 2;
        d0 = done_cnt;
        do_start(2, 1'b1);
        wait_done(100);
        chk("n4_first_issue_lat", first_hs - start_cyc, 1);
        chk("n4_first_col_lat", first_col - start_cyc, 7);
        chk("n4_done_lat", done_cyc - start_cyc, 13);
        chk("n4_handshakes", hs_total - hs_base, 8);
        chk("n4_done_pulses", done_cnt - d0, 1);
        chk("n4_err", int'(cfg_err), 0);
        chk("n4_busy_after", int'(cfg_busy), 0);
`ifdef DCT_PASS_SEQ_PERF_CNT_EN
        chk("n4_perf", int'(perf_cycles), 13);
`endif

        // Illegal size, then a legal size-3 start.
        do_start(6, 1'b0);
        bad = 0;
        repeat (5) begin
            @(negedge ACLK);
            if (kif.krn_valid || cfg_busy) bad++;
        end
        chk("illegal_no_activity", bad, 0);
        chk("illegal_err", int'(cfg_err), 1);
        d0 = done_cnt;
        do_start(3, 1'b1);
        @(negedge ACLK);
        chk("legal_err_cleared", int'(cfg_err), 0);
        chk("legal_busy", int'(cfg_busy), 1);
        wait_done(200);
        chk("n8_handshakes", hs_total - hs_base, 16);
        chk("n8_done_pulses", done_cnt - d0, 1);

        // N=32, delay 10: saturates at the limit; a start while busy is ignored.
        res_delay = 10;
        d0 = done_cnt;
        do_start(5, 1'b1);
        repeat (20) @(posedge ACLK);
        #1;
        cfg_start     = 1'b1;
        cfg_size_log2 = 3'd6;
        @(posedge ACLK);
        #1;
        cfg_start = 1'b0;
        wait_done(2000);
        chk("n32_handshakes", hs_total - hs_base, 64);
        chk("n32_max_outstanding", max_out, MAX_OUT);
        chk("n32_done_pulses", done_cnt - d0, 1);
        chk("n32_busy_start_no_err", int'(cfg_err), 0);

        // N=8, delay 3: steady same-cycle issue and return at outstanding 3.
        res_delay = 3;
        do_start(3, 1'b1);
        wait_done(200);
        chk("same3_events", int'(same3 > 0), 1);
        chk("same3_max_outstanding", max_out, 3);
        chk("same3_done_lat", done_cyc - start_cyc, 23);
        chk("same3_handshakes", hs_total - hs_base, 16);

        // Abort after 5 of 8 row issues with 2 outstanding.
        res_delay = 2;
        d0 = done_cnt;
        do_start(3, 1'b1);
        k = 0;
        while (hs_total - hs_base < 5 && k < 50) begin
            @(posedge ACLK);
            #1;
            k++;
        end
        kif.krn_ready = 1'b0;
        cfg_abort     = 1'b1;
        t_abort       = cyc;
        chk("abort_outstanding", out_model, 2);
        @(posedge ACLK);
        #1;
        cfg_abort = 1'b0;
        @(negedge ACLK);
        chk("abort_valid_drop", int'(kif.krn_valid), 0);
        k = 0;
        while (cfg_busy && k < 50) begin
            @(negedge ACLK);
            k++;
        end
        chk("abort_idle_lat", cyc - t_abort, 2);
        chk("abort_err", int'(cfg_err), 1);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_handshakes", hs_total - hs_base, 5);
        chk("abort_drained", out_model, 0);
        kif.krn_ready = 1'b1;

        // Reset mid column pass, then a clean run.
        do_start(3, 1'b1);
        chk("rst_run_err_cleared", int'(cfg_err), 0);
        k = 0;
        while (first_col < 0 && k < 100) begin
            @(posedge ACLK);
            k++;
        end
        chk("rst_col_reached", int'(first_col >= 0), 1);
        @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        @(negedge ACLK);
        check_reset_outs();
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        exp_q.delete();
        repeat (20) @(posedge ACLK);
        @(negedge ACLK);
        chk("post_rst_idle", int'(cfg_busy), 0);
        chk("post_rst_no_valid", int'(kif.krn_valid), 0);
        d0 = done_cnt;
        do_start(2, 1'b1);
        wait_done(100);
        chk("post_rst_done_lat", done_cyc - start_cyc, 13);
        chk("post_rst_handshakes", hs_total - hs_base, 8);
        chk("post_rst_done_pulses", done_cnt - d0, 1);
        chk("post_rst_err", int'(cfg_err), 0);
`ifdef DCT_PASS_SEQ_PERF_CNT_EN
        chk("post_rst_perf", int'(perf_cycles), 13);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
